// File: rtl/pixel_effect_pipe.sv
// pixel_effect_pipe: three-stage per-frame colour effect
// (pass, invert, gray, threshold, posterize) for the video path.
module pixel_effect_pipe #(
  parameter int W          = 8,
  parameter int POST_BITS  = 3,
  parameter int THRESH_RST = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_sof,
  input  logic [W-1:0] r_in,
  input  logic [W-1:0] g_in,
  input  logic [W-1:0] b_in,
  input  logic [2:0]   mode_in,
  input  logic [W-1:0] thresh_in,
  output logic         out_valid,
  output logic         out_sof,
  output logic [W-1:0] r_out,
  output logic [W-1:0] g_out,
  output logic [W-1:0] b_out,
  output logic [2:0]   active_mode
);

  localparam logic [2:0] M_INV  = 3'd1;
  localparam logic [2:0] M_GRAY = 3'd2;
  localparam logic [2:0] M_THR  = 3'd3;
  localparam logic [2:0] M_POST = 3'd4;

  localparam int         LOW   = W - POST_BITS;
  localparam logic [W-1:0] MAXV  = '1;
  localparam logic [W-1:0] PMASK = MAXV << LOW;

  typedef struct packed {
    logic         sof;
    logic [2:0]   mode;
    logic [W-1:0] thr;
    logic [W-1:0] r;
    logic [W-1:0] g;
    logic [W-1:0] b;
    logic [W+7:0] pr;
    logic [W+7:0] pg;
    logic [W+7:0] pb;
  } s1_t;

  typedef struct packed {
    logic         sof;
    logic [2:0]   mode;
    logic [W-1:0] thr;
    logic [W-1:0] r;
    logic [W-1:0] g;
    logic [W-1:0] b;
    logic [W-1:0] gray;
  } s2_t;

  logic         sof_take;
  logic [2:0]   eff_mode;
  logic [W-1:0] eff_thr;
  logic [W-1:0] act_thr;

  logic         v1;
  logic         v2;
  s1_t          s1;
  s2_t          s2;
  logic [W+9:0] sum;
  logic [W-1:0] gray_c;
  logic [W-1:0] ro;
  logic [W-1:0] go;
  logic [W-1:0] bo;

  // The sof pixel itself already uses the config it carries
  assign sof_take = in_valid & in_sof;
  assign eff_mode = sof_take ? mode_in : active_mode;
  assign eff_thr  = sof_take ? thresh_in : act_thr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_mode <= '0;
      act_thr     <= W'(THRESH_RST);
    end else if (sof_take) begin
      active_mode <= mode_in;
      act_thr     <= thresh_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0;
      s1 <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        s1.sof  <= in_sof;
        s1.mode <= eff_mode;
        s1.thr  <= eff_thr;
        s1.r    <= r_in;
        s1.g    <= g_in;
        s1.b    <= b_in;
        s1.pr   <= (W+8)'(r_in) * (W+8)'(77);
        s1.pg   <= (W+8)'(g_in) * (W+8)'(150);
        s1.pb   <= (W+8)'(b_in) * (W+8)'(29);
      end
    end
  end

  // Weights sum to 256, so the top bits never exceed MAXV
  assign sum    = (W+10)'(s1.pr) + (W+10)'(s1.pg)
                + (W+10)'(s1.pb);
  assign gray_c = W'(sum >> 8);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2 <= 1'b0;
      s2 <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        s2.sof  <= s1.sof;
        s2.mode <= s1.mode;
        s2.thr  <= s1.thr;
        s2.r    <= s1.r;
        s2.g    <= s1.g;
        s2.b    <= s1.b;
        s2.gray <= gray_c;
      end
    end
  end

  always_comb begin
    ro = s2.r;
    go = s2.g;
    bo = s2.b;
    case (s2.mode)
      M_INV: begin
        ro = MAXV - s2.r;
        go = MAXV - s2.g;
        bo = MAXV - s2.b;
      end
      M_GRAY: begin
        ro = s2.gray;
        go = s2.gray;
        bo = s2.gray;
      end
      M_THR: begin
        ro = (s2.gray >= s2.thr) ? MAXV : '0;
        go = ro;
        bo = ro;
      end
      M_POST: begin
        ro = s2.r & PMASK;
        go = s2.g & PMASK;
        bo = s2.b & PMASK;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      r_out     <= '0;
      g_out     <= '0;
      b_out     <= '0;
    end else begin
      out_valid <= v2;
      out_sof   <= v2 & s2.sof;
      if (v2) begin
        r_out <= ro;
        g_out <= go;
        b_out <= bo;
      end
    end
  end

endmodule

// File: tb/tb_pixel_effect_pipe.sv
// tb_pixel_effect_pipe: directed + random stimulus
// against a queue-based arithmetic reference model.
module tb_pixel_effect_pipe;

  localparam int W    = 8;
  localparam int PB   = 3;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_sof = 1'b0;
  logic [W-1:0] r_in = '0;
  logic [W-1:0] g_in = '0;
  logic [W-1:0] b_in = '0;
  logic [2:0]   mode_in = '0;
  logic [W-1:0] thresh_in = '0;
  logic         out_valid;
  logic         out_sof;
  logic [W-1:0] r_out;
  logic [W-1:0] g_out;
  logic [W-1:0] b_out;
  logic [2:0]   active_mode;

  pixel_effect_pipe #(
    .W(W), .POST_BITS(PB), .THRESH_RST(128)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sof(in_sof),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .mode_in(mode_in), .thresh_in(thresh_in),
    .out_valid(out_valid), .out_sof(out_sof),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .active_mode(active_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v;
    int s;
    int rgb;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_rgb = 0;
  int   m_mode = 0;
  int   m_thr = 128;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int pack(int r, int g, int b);
    return (r << (2*W)) | (g << W) | b;
  endfunction

  function automatic int fx(int m, int t,
                            int r, int g, int b);
    int y;
    int lo;
    y  = (77*r + 150*g + 29*b) / 256;
    lo = W - PB;
    case (m)
      1: return pack(MAXV-r, MAXV-g, MAXV-b);
      2: return pack(y, y, y);
      3: return (y >= t) ? pack(MAXV, MAXV, MAXV) : 0;
      4: return pack((r >> lo) << lo,
                     (g >> lo) << lo,
                     (b >> lo) << lo);
      default: return pack(r, g, b);
    endcase
  endfunction

  task automatic check_out();
    exp_t e;
    e = '{0, 0, 0};
    if (q.size() == 3) e = q.pop_front();
    if (e.v != 0) last_rgb = e.rgb;
    chk("out_valid", 32'(out_valid), 32'(e.v));
    chk("out_sof", 32'(out_sof), 32'(e.s));
    chk("rgb", 32'({r_out, g_out, b_out}), 32'(last_rgb));
    if (m_mode < 5)
      chk("active_mode", 32'(active_mode), 32'(m_mode));
  endtask

  task automatic step(int v, int s, int r, int g, int b,
                      int m, int t);
    exp_t e;
    int   em;
    int   et;
    @(negedge clk);
    check_out();
    in_valid  = (v != 0);
    in_sof    = (s != 0);
    r_in      = W'(r);
    g_in      = W'(g);
    b_in      = W'(b);
    mode_in   = 3'(m);
    thresh_in = W'(t);
    em = (v != 0 && s != 0) ? m : m_mode;
    et = (v != 0 && s != 0) ? t : m_thr;
    e.v   = (v != 0) ? 1 : 0;
    e.s   = (v != 0 && s != 0) ? 1 : 0;
    e.rgb = (v != 0) ? fx(em, et, r, g, b) : 0;
    q.push_back(e);
    if (v != 0 && s != 0) begin
      m_mode = m;
      m_thr  = t;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sof", 32'(out_sof), 32'd0);
    chk("rst_rgb", 32'({r_out, g_out, b_out}), 32'd0);
    chk("rst_mode", 32'(active_mode), 32'd0);
    rst = 1'b1;

    step(1, 1, 10, 200, 255, 1, 0);
    repeat (3) idle();
    step(1, 1, 255, 255, 255, 2, 0);
    step(1, 0, 100, 50, 200, 0, 0);
    step(1, 1, 100, 50, 200, 3, 82);
    step(1, 0, 99, 50, 200, 1, 7);
    step(1, 1, 20, 40, 60, 1, 0);
    for (int i = 0; i < 5; i++)
      step(1, 0, $urandom_range(MAXV), $urandom_range(MAXV),
           $urandom_range(MAXV), 2, 0);
    step(1, 1, 30, 90, 150, 2, 0);
    step(1, 0, 100, 50, 200, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 2, 3, 0, 0);
    step(1, 0, 250, 128, 7, 0, 0);
    step(0, 1, 9, 9, 9, 1, 0);
    step(1, 1, 'hB7, 'hB7, 'h1F, 4, 0);
    step(1, 1, 11, 22, 33, 6, 0);
    step(1, 1, 11, 22, 33, 1, 0);
    step(1, 1, 80, 80, 80, 3, 80);
    step(1, 1, 80, 80, 80, 3, 81);
    repeat (3) idle();

    step(1, 0, 5, 6, 7, 0, 0);
    step(1, 0, 50, 60, 70, 0, 0);
    step(1, 0, 150, 160, 170, 0, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sof", 32'(out_sof), 32'd0);
    chk("mid_rst_rgb", 32'({r_out, g_out, b_out}), 32'd0);
    chk("mid_rst_mode", 32'(active_mode), 32'd0);
    q.delete();
    last_rgb = 0;
    m_mode = 0;
    m_thr = 128;
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 12, 34, 56, 3, 1);
    repeat (4) idle();

    for (int i = 0; i < 400; i++)
      step(($urandom_range(9) < 7) ? 1 : 0,
           ($urandom_range(11) == 0) ? 1 : 0,
           $urandom_range(MAXV), $urandom_range(MAXV),
           $urandom_range(MAXV), $urandom_range(7),
           $urandom_range(MAXV));
    repeat (4) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
